// File: rtl/key_scheduler_inverse_sequential_pkg.sv
// Shared constants, state encoding and AES byte/word helpers for the
// inverse AES-256 key scheduler.
package key_scheduler_inverse_sequential_pkg;

  localparam int unsigned N_BYTES_WORD = 4;
  localparam int unsigned NB_WORD      = 32;
  localparam int unsigned NK           = 8;
  localparam int unsigned NB_ROUND_IDX = 4;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  // Forward AES S-box, entry 0 at the MSBs.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry x starts at bit 2047-8x, which is {~x, 3'b111}.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TABLE[{~x, 3'b111} -: 8];
  endfunction

  function automatic logic [NB_WORD-1:0] sub_word(input logic [NB_WORD-1:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [NB_WORD-1:0] rot_word(input logic [NB_WORD-1:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [7:0] rcon(input logic [NB_ROUND_IDX-2:0] idx);
    logic [7:0] v;
    case (idx)
      3'd1:    v = 8'h01;
      3'd2:    v = 8'h02;
      3'd3:    v = 8'h04;
      3'd4:    v = 8'h08;
      3'd5:    v = 8'h10;
      3'd6:    v = 8'h20;
      3'd7:    v = 8'h40;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/key_scheduler_inverse_sequential_nwords.sv
// Combinational backward step of the AES-256 key schedule: from the top round
// key and the word just below it, derives the four words eight positions lower.
module key_scheduler_inverse_nwords
  import key_scheduler_inverse_sequential_pkg::*;
(
  input  logic [N_BYTES_WORD*NB_WORD-1:0] i_top,
  input  logic [NB_WORD-1:0]              i_prev_word,
  input  logic [NB_ROUND_IDX-1:0]         i_round,
  output logic [N_BYTES_WORD*NB_WORD-1:0] o_new4
);

  localparam int unsigned NB_NEW = N_BYTES_WORD * NB_WORD;

  logic [NB_WORD-1:0] w_sbox_in;
  logic [NB_WORD-1:0] w_rcon_word;
  logic [NB_WORD-1:0] w_t;

  // Even r means i=4r is a multiple of 8 (RotWord+Rcon); odd r is the NK=8 extra SubWord.
  always_comb begin
    w_sbox_in   = i_round[0] ? i_prev_word : rot_word(i_prev_word);
    w_rcon_word = i_round[0] ? '0
                             : {rcon(i_round[NB_ROUND_IDX-1:1]), {(NB_WORD-8){1'b0}}};
    w_t         = sub_word(w_sbox_in) ^ w_rcon_word;
  end

  // w[i-8] = w[i] ^ t(w[i-1]); for k>0 the w[i-1] operand is the previous top word.
  always_comb begin
    o_new4 = '0;
    if (i_round > NB_ROUND_IDX'(1)) begin
      o_new4[NB_NEW-1 -: NB_WORD] = i_top[NB_NEW-1 -: NB_WORD] ^ w_t;
      for (int unsigned k = 1; k < N_BYTES_WORD; k++) begin
        o_new4[NB_NEW-1-NB_WORD*k -: NB_WORD] =
          i_top[NB_NEW-1-NB_WORD*k -: NB_WORD] ^ i_top[NB_NEW-1-NB_WORD*(k-1) -: NB_WORD];
      end
    end
  end

endmodule

// File: rtl/key_scheduler_inverse_sequential.sv
// AES-256 inverse key expansion: streams RK14..RK0 over valid/ready.
// Optional o_cipher_key output under KEY_SCHED_INV_CIPHER_KEY_OUT_EN.
module key_scheduler_inverse_sequential
  import key_scheduler_inverse_sequential_pkg::*;
#(
  parameter int unsigned NB_BYTE       = 8,
  parameter int unsigned N_BYTES_STATE = 16,
  parameter int unsigned N_BYTES_KEY   = 32,
  parameter int unsigned N_ROUNDS      = 14
) (
  input  logic                             i_clock,
  input  logic                             i_reset_n,
  input  logic                             i_valid,
  input  logic                             i_trigger_schedule,
  input  logic [NB_BYTE*N_BYTES_KEY-1:0]   i_last_keys,
  input  logic                             i_round_key_ready,
  output logic [NB_BYTE*N_BYTES_STATE-1:0] o_round_key,
  output logic                             o_round_key_valid,
  output logic [NB_ROUND_IDX-1:0]          o_round_index,
  output logic                             o_busy,
  output logic                             o_done
`ifdef KEY_SCHED_INV_CIPHER_KEY_OUT_EN
  ,
  output logic [NB_BYTE*N_BYTES_KEY-1:0]   o_cipher_key
`endif
);

  localparam int unsigned NB_STATE  = NB_BYTE * N_BYTES_STATE;
  localparam int unsigned NB_WINDOW = NK * NB_WORD;

  state_t                  r_state;
  logic [NB_WINDOW-1:0]    r_window;
  logic [NB_ROUND_IDX-1:0] r_round;
  logic                    r_valid;
  logic                    r_done;
  logic [NB_STATE-1:0]     w_new4;
  logic                    w_handshake;

  assign w_handshake = i_valid & r_valid & i_round_key_ready;

  key_scheduler_inverse_nwords u_nwords (
    .i_top       (r_window[NB_WINDOW-1 -: NB_STATE]),
    .i_prev_word (r_window[NB_WORD-1:0]),
    .i_round     (r_round),
    .o_new4      (w_new4)
  );

  // Trigger takes priority over a same-cycle handshake, aborting the old run silently.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state  <= ST_IDLE;
      r_window <= '0;
      r_round  <= '0;
      r_valid  <= 1'b0;
      r_done   <= 1'b0;
    end else if (i_valid) begin
      r_done <= 1'b0;
      if (i_trigger_schedule) begin
        r_state  <= ST_STREAM;
        r_window <= i_last_keys;
        r_round  <= NB_ROUND_IDX'(N_ROUNDS);
        r_valid  <= 1'b1;
      end else if (w_handshake) begin
        r_window <= {r_window[NB_WINDOW-NB_STATE-1:0], w_new4};
        if (r_round == '0) begin
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
          r_done  <= 1'b1;
        end else begin
          r_round <= r_round - NB_ROUND_IDX'(1);
        end
      end
    end
  end

`ifdef KEY_SCHED_INV_CIPHER_KEY_OUT_EN
  logic [NB_WINDOW-1:0] r_cipher_key;

  // At r==1 the window is {RK1,RK0} = {w4..w7,w0..w3}; swap halves to get w0 first.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_cipher_key <= '0;
    end else if (i_valid && !i_trigger_schedule && w_handshake
                 && r_round == NB_ROUND_IDX'(1)) begin
      r_cipher_key <= {r_window[NB_WINDOW-NB_STATE-1:0], r_window[NB_WINDOW-1 -: NB_STATE]};
    end
  end

  assign o_cipher_key = r_cipher_key;
`endif

  assign o_round_key       = r_window[NB_WINDOW-1 -: NB_STATE];
  assign o_round_key_valid = r_valid;
  assign o_round_index     = r_round;
  assign o_busy            = (r_state == ST_STREAM);
  assign o_done            = r_done;

endmodule

// File: tb/tb_key_scheduler_inverse_sequential.sv
// Scoreboard bench for key_scheduler_inverse_sequential; expected round keys come
// from a forward AES-256 key expansion with an S-box derived from GF(2^8) inversion.
module tb_key_scheduler_inverse_sequential;

  logic         i_clock            = 1'b0;
  logic         i_reset_n          = 1'b0;
  logic         i_valid            = 1'b0;
  logic         i_trigger_schedule = 1'b0;
  logic [255:0] i_last_keys        = '0;
  logic         i_round_key_ready  = 1'b1;
  logic [127:0] o_round_key;
  logic         o_round_key_valid;
  logic [3:0]   o_round_index;
  logic         o_busy;
  logic         o_done;
`ifdef KEY_SCHED_INV_CIPHER_KEY_OUT_EN
  logic [255:0] o_cipher_key;
  localparam int unsigned N_RAND = 100;
`else
  localparam int unsigned N_RAND = 4;
`endif

  localparam logic [255:0] FIPS_KEY  =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] FIPS_LAST =
    {128'h24fc79ccbf0979e9371ac23c6d68de36, 128'h4e5a6699a9f24fe07e572baacdf8cdea};

  key_scheduler_inverse_sequential #(
    .NB_BYTE       (8),
    .N_BYTES_STATE (16),
    .N_BYTES_KEY   (32),
    .N_ROUNDS      (14)
  ) dut (
    .i_clock            (i_clock),
    .i_reset_n          (i_reset_n),
    .i_valid            (i_valid),
    .i_trigger_schedule (i_trigger_schedule),
    .i_last_keys        (i_last_keys),
    .i_round_key_ready  (i_round_key_ready),
    .o_round_key        (o_round_key),
    .o_round_key_valid  (o_round_key_valid),
    .o_round_index      (o_round_index),
    .o_busy             (o_busy),
    .o_done             (o_done)
`ifdef KEY_SCHED_INV_CIPHER_KEY_OUT_EN
    ,
    .o_cipher_key       (o_cipher_key)
`endif
  );

  always #5 i_clock = ~i_clock;

  int unsigned  n_vec = 0;
  int unsigned  n_err = 0;
  logic [131:0] exp_q[$];
  logic [7:0]   sbox_m[256];
  logic [31:0]  w_m[60];
  logic         rand_ready = 1'b0;
  logic         prev_hold  = 1'b0;
  logic         prev_last  = 1'b0;
  logic [127:0] prev_key   = '0;
  logic [3:0]   prev_idx   = '0;
  logic [255:0] cur_key    = '0;
  logic         timed_out;

  task automatic check_value(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = '0; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = xtime(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [7:0] r;
    r = (b << n) | (b >> (8 - n));
    return r;
  endfunction

  task automatic build_sbox();
    logic [7:0] xb, inv;
    for (int x = 0; x < 256; x++) begin
      xb  = 8'(x);
      inv = '0;
      for (int y = 1; y < 256; y++)
        if (gmul(xb, 8'(y)) == 8'h01) inv = 8'(y);
      sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
  endfunction

  function automatic void expand(input logic [255:0] key);
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 8; i++) w_m[i] = key[255-32*i -: 32];
    rc = 8'h01;
    for (int i = 8; i < 60; i++) begin
      t = w_m[i-1];
      if (i % 8 == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xtime(rc);
      end else if (i % 8 == 4) begin
        t = subw(t);
      end
      w_m[i] = w_m[i-8] ^ t;
    end
  endfunction

  function automatic logic [127:0] rk(input int r);
    return {w_m[4*r], w_m[4*r+1], w_m[4*r+2], w_m[4*r+3]};
  endfunction

  function automatic logic [255:0] model_last(input logic [255:0] key);
    expand(key);
    return {rk(14), rk(13)};
  endfunction

  function automatic logic [255:0] rand_key();
    logic [255:0] k;
    for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
    return k;
  endfunction

  always @(posedge i_clock) begin
    #1;
    i_round_key_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: beats vs scoreboard, stability while stalled, o_done timing.
  always @(negedge i_clock) begin
    logic         hs;
    logic [131:0] e;
    if (!i_reset_n) begin
      prev_hold = 1'b0;
      prev_last = 1'b0;
    end else begin
      if (prev_hold) begin
        check_value("stall_key", 256'(o_round_key), 256'(prev_key));
        check_value("stall_idx", 256'(o_round_index), 256'(prev_idx));
      end
      check_value("done", 256'(o_done), 256'(prev_last));
      hs = i_valid && o_round_key_valid && i_round_key_ready && !i_trigger_schedule;
      if (hs) begin
        if (exp_q.size() == 0) begin
          check_value("unexpected_beat", 256'(o_round_index), 256'(4'hf));
        end else begin
          e = exp_q.pop_front();
          check_value("beat_key", 256'(o_round_key), 256'(e[127:0]));
          check_value("beat_idx", 256'(o_round_index), 256'(e[131:128]));
        end
      end
      prev_last = hs && (o_round_index == 4'd0);
      prev_hold = o_round_key_valid && !(i_valid && (i_round_key_ready || i_trigger_schedule));
      prev_key  = o_round_key;
      prev_idx  = o_round_index;
    end
  end

  task automatic start_run(input logic [255:0] key, input logic [255:0] last);
    @(posedge i_clock); #1;
    expand(key);
    exp_q.delete();
    for (int r = 14; r >= 0; r--) exp_q.push_back({4'(r), rk(r)});
    cur_key            = key;
    i_last_keys        = last;
    i_trigger_schedule = 1'b1;
    @(posedge i_clock); #1;
    i_trigger_schedule = 1'b0;
  endtask

  task automatic wait_index(input logic [3:0] idx);
    timed_out = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge i_clock);
      if (o_round_key_valid && o_round_index == idx) begin
        timed_out = 1'b0;
        break;
      end
    end
    check_value("reach_index", 256'(timed_out), 256'(1'b0));
  endtask

  task automatic wait_done();
    timed_out = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge i_clock);
      if (exp_q.size() == 0 && !o_busy) begin
        timed_out = 1'b0;
        break;
      end
    end
    check_value("run_complete", 256'(timed_out), 256'(1'b0));
    check_value("idle_valid", 256'(o_round_key_valid), 256'(1'b0));
`ifdef KEY_SCHED_INV_CIPHER_KEY_OUT_EN
    check_value("cipher_key", o_cipher_key, cur_key);
`endif
  endtask

  task automatic check_zero_outputs(input string tag);
    check_value({tag, "_key"}, 256'(o_round_key), '0);
    check_value({tag, "_valid"}, 256'(o_round_key_valid), '0);
    check_value({tag, "_idx"}, 256'(o_round_index), '0);
    check_value({tag, "_busy"}, 256'(o_busy), '0);
    check_value({tag, "_done"}, 256'(o_done), '0);
  endtask

  initial begin
    logic [255:0] ka, kb;
    build_sbox();
    #2;
    check_zero_outputs("reset");
    #10 i_reset_n = 1'b1;
    i_valid = 1'b1;

    // FIPS-197 vector, ready held high
    start_run(FIPS_KEY, FIPS_LAST);
    wait_done();

    // same vector, random back-pressure
    rand_ready = 1'b1;
    start_run(FIPS_KEY, FIPS_LAST);
    wait_done();

    // restart mid-stream with a new key pair
    ka = rand_key();
    kb = rand_key();
    start_run(ka, model_last(ka));
    wait_index(4'd7);
    start_run(kb, model_last(kb));
    wait_done();

    // global enable dropped for 5 cycles mid-stream
    rand_ready = 1'b0;
    start_run(FIPS_KEY, FIPS_LAST);
    wait_index(4'd9);
    @(posedge i_clock); #1;
    i_valid = 1'b0;
    repeat (5) @(posedge i_clock);
    #1;
    i_valid = 1'b1;
    wait_done();

    // asynchronous reset mid-stream, then a clean run
    start_run(FIPS_KEY, FIPS_LAST);
    wait_index(4'd3);
    #2 i_reset_n = 1'b0;
    #1 check_zero_outputs("async_rst");
    exp_q.delete();
    @(negedge i_clock);
    #2 i_reset_n = 1'b1;
    start_run(FIPS_KEY, FIPS_LAST);
    wait_done();

    // random keys with random ready
    rand_ready = 1'b1;
    for (int n = 0; n < int'(N_RAND); n++) begin
      ka = rand_key();
      start_run(ka, model_last(ka));
      wait_done();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
